// File: rtl/oht2bin_pipe.sv
// Pipelined one-hot to binary encoder with per-stage valid/ready handshake.
// Optional non-one-hot flagging is built only when OHT2BIN_PIPE_ERR_EN is defined.
module oht2bin_pipe #(
    parameter int  WIDTH     = 32,
    parameter int  STAGES    = 2,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld_i,
    output logic                 rdy_o,
    input  logic [WIDTH-1:0]     oht,
    output logic                 vld_o,
    input  logic                 rdy_i,
    output logic [WIDTH_LOG-1:0] bin,
    output logic                 err
);

    localparam int PAD = 1 << WIDTH_LOG;

`ifdef OHT2BIN_PIPE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Stage k sits after tree level ceil(k*WIDTH_LOG/STAGES); 0 means the level is not registered.
    function automatic int stage_of(input int level);
        int hit;
        hit = 0;
        for (int k = 1; k <= STAGES; k++) begin
            if ((k * WIDTH_LOG + STAGES - 1) / STAGES == level) begin
                hit = k;
            end
        end
        return hit;
    endfunction

    genvar gi, gn;

    generate
        if (STAGES > 0) begin : hs
            logic [STAGES+1:1] load;
            logic [STAGES:1]   vld_reg;
            logic [STAGES:0]   vld_chain;
            logic [STAGES:1]   stage_en;

            assign vld_chain       = {vld_reg, vld_i};
            assign load[STAGES+1]  = rdy_i;

            for (gi = 1; gi <= STAGES; gi++) begin : st
                assign load[gi]     = !vld_reg[gi] || load[gi+1];
                // Data only moves with a real item so registers never pick up bubbles.
                assign stage_en[gi] = load[gi] && vld_chain[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_reg <= '0;
                end else begin
                    for (int s = 1; s <= STAGES; s++) begin
                        if (load[s]) begin
                            vld_reg[s] <= vld_chain[s-1];
                        end
                    end
                end
            end

            assign rdy_o = load[1];
            assign vld_o = vld_chain[STAGES];
        end else begin : comb_hs
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign rdy_o          = rdy_i;
            assign vld_o          = vld_i;
        end
    endgenerate

    generate
        for (gi = 0; gi <= WIDTH_LOG; gi++) begin : lvl
            localparam int NODES = PAD >> gi;
            localparam int SK    = stage_of(gi);

            logic [WIDTH_LOG-1:0] cbin [NODES];
            logic [WIDTH_LOG-1:0] obin [NODES];

            if (gi == 0) begin : leaf
                for (gn = 0; gn < NODES; gn++) begin : node
                    assign cbin[gn] = '0;
                end
            end else begin : tree
                localparam logic [WIDTH_LOG-1:0] TOP = WIDTH_LOG'(1) << (gi - 1);
                for (gn = 0; gn < NODES; gn++) begin : node
                    // Right child occupied means the new index bit for this level is set.
                    assign cbin[gn] = lvl[gi-1].obin[2*gn] | lvl[gi-1].obin[2*gn+1]
                                    | (lvl[gi-1].fl.onone[2*gn+1] ? '0 : TOP);
                end
            end

            if (SK > 0) begin : bin_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int n = 0; n < NODES; n++) begin
                            obin[n] <= '0;
                        end
                    end else if (hs.stage_en[SK]) begin
                        obin <= cbin;
                    end
                end
            end else begin : bin_thru
                assign obin = cbin;
            end

            // "none" is the inverted any flag, so registers reset to 0 read as err=0.
            if ((gi < WIDTH_LOG) || ERR_EN) begin : fl
                logic cnone [NODES];
                logic onone [NODES];

                for (gn = 0; gn < NODES; gn++) begin : node
                    if (gi == 0) begin : leaf
                        if (gn < WIDTH) begin : real_bit
                            assign cnone[gn] = !oht[gn];
                        end else begin : pad_bit
                            assign cnone[gn] = 1'b1;
                        end
                    end else begin : merge
                        assign cnone[gn] = lvl[gi-1].fl.onone[2*gn] && lvl[gi-1].fl.onone[2*gn+1];
                    end
                end

                if (SK > 0) begin : none_reg
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            for (int n = 0; n < NODES; n++) begin
                                onone[n] <= 1'b0;
                            end
                        end else if (hs.stage_en[SK]) begin
                            onone <= cnone;
                        end
                    end
                end else begin : none_thru
                    assign onone = cnone;
                end
            end

`ifdef OHT2BIN_PIPE_ERR_EN
            if (ERR_EN) begin : ml
                logic cmulti [NODES];
                logic omulti [NODES];

                for (gn = 0; gn < NODES; gn++) begin : node
                    if (gi == 0) begin : leaf
                        assign cmulti[gn] = 1'b0;
                    end else begin : merge
                        assign cmulti[gn] = lvl[gi-1].ml.omulti[2*gn] || lvl[gi-1].ml.omulti[2*gn+1]
                                          || (!lvl[gi-1].fl.onone[2*gn] && !lvl[gi-1].fl.onone[2*gn+1]);
                    end
                end

                if (SK > 0) begin : multi_reg
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            for (int n = 0; n < NODES; n++) begin
                                omulti[n] <= 1'b0;
                            end
                        end else if (hs.stage_en[SK]) begin
                            omulti <= cmulti;
                        end
                    end
                end else begin : multi_thru
                    assign omulti = cmulti;
                end
            end
`endif
        end
    endgenerate

    assign bin = lvl[WIDTH_LOG].obin[0];

`ifdef OHT2BIN_PIPE_ERR_EN
    assign err = lvl[WIDTH_LOG].fl.onone[0] || lvl[WIDTH_LOG].ml.omulti[0];
`else
    assign err = 1'b0;
`endif

endmodule
